// File: rtl/truth_table_sequencer_pkg.sv
// Shared definitions for the truth-table sweep controller: state encodings
// and the table-depth helper used by the top, the interface and the capture block.
package truth_table_sequencer_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_APPLY  = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_APPLY  = ST_APPLY,
    S_SAMPLE = ST_SAMPLE,
    S_FINISH = ST_FINISH
  } state_e;

  // Number of entries in a truth table for an n-input function.
  function automatic int tt_depth(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/truth_table_sequencer_if.sv
// Bundle between the sweep controller (slave side) and the bench/top plus the
// pair of function implementations under comparison (master side).
interface truth_table_sequencer_if
  import truth_table_sequencer_pkg::*;
#(
  parameter int N_IN = 2
);
  localparam int DEPTH = tt_depth(N_IN);

  logic              start;
  logic              abort;
  logic              a_in;
  logic              b_in;
  logic [N_IN-1:0]   x_vec;
  logic              busy;
  logic              done;
  logic [DEPTH-1:0]  table_a;
  logic [DEPTH-1:0]  table_b;
  logic [DEPTH-1:0]  mismatch_mask;
  logic              mismatch;
  logic [N_IN-1:0]   first_fail;

  modport master (
    output start, abort, a_in, b_in,
    input  x_vec, busy, done, table_a, table_b, mismatch_mask, mismatch, first_fail
  );

  modport slave (
    input  start, abort, a_in, b_in,
    output x_vec, busy, done, table_a, table_b, mismatch_mask, mismatch, first_fail
  );

endinterface

// File: rtl/truth_table_sequencer_tt_capture.sv
// Truth-table capture register: one bit per input combination for each
// implementation, plus their XOR mask, written one index at a time.
module tt_capture #(
  parameter int IDX_W = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             a_i,
  input  logic             b_i,
  output logic [DEPTH-1:0] table_a_o,
  output logic [DEPTH-1:0] table_b_o,
  output logic [DEPTH-1:0] mask_o
);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_bit
    logic ta_q;
    logic tb_q;
    logic mask_q;
    logic hit_d;

    assign hit_d = we_i && (idx_i == IDX_W'(gi));

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        ta_q   <= 1'b0;
        tb_q   <= 1'b0;
        mask_q <= 1'b0;
      end else if (clr_i) begin
        ta_q   <= 1'b0;
        tb_q   <= 1'b0;
        mask_q <= 1'b0;
      end else if (hit_d) begin
        ta_q   <= a_i;
        tb_q   <= b_i;
        mask_q <= a_i ^ b_i;
      end
    end

    assign table_a_o[gi] = ta_q;
    assign table_b_o[gi] = tb_q;
    assign mask_o[gi]    = mask_q;
  end

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps x_vec through every input combination, samples both implementations
// after a settle delay, and reports the captured tables and the first mismatch.
module truth_table_sequencer
  import truth_table_sequencer_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  truth_table_sequencer_if.slave   bus
);

  localparam int DEPTH = tt_depth(N_IN);
  localparam logic [N_IN:0] LAST_IDX = (N_IN+1)'(DEPTH - 1);
  localparam logic [3:0]    SETTLE_W = 4'(SETTLE);

  state_e            state_q;
  logic [N_IN:0]     index_q;
  logic [3:0]        settle_q;
  logic [N_IN-1:0]   x_vec_q;
  logic [N_IN-1:0]   first_fail_q;
  logic              busy_q;
  logic              done_q;
  logic              mismatch_q;
  logic              fail_seen_q;

  logic [N_IN:0]     index_d;
  logic              diff_d;
  logic              last_d;
  logic              cap_clr_d;
  logic              cap_we_d;
  logic [DEPTH-1:0]  table_a_w;
  logic [DEPTH-1:0]  table_b_w;
  logic [DEPTH-1:0]  mask_w;

  assign index_d   = index_q + (N_IN+1)'(1);
  assign diff_d    = bus.a_in ^ bus.b_in;
  assign last_d    = (index_q == LAST_IDX);
  assign cap_clr_d = (state_q == S_IDLE) && bus.start;
  // abort wins over the capture of the index being sampled
  assign cap_we_d  = (state_q == S_SAMPLE) && !bus.abort;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      index_q      <= '0;
      settle_q     <= '0;
      x_vec_q      <= '0;
      first_fail_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mismatch_q   <= 1'b0;
      fail_seen_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q      <= S_APPLY;
            index_q      <= '0;
            settle_q     <= '0;
            x_vec_q      <= '0;
            busy_q       <= 1'b1;
            first_fail_q <= '0;
            fail_seen_q  <= 1'b0;
          end
        end
        S_APPLY: begin
          if (bus.abort) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            settle_q <= '0;
          end else if (settle_q == SETTLE_W) begin
            state_q  <= S_SAMPLE;
            settle_q <= '0;
          end else begin
            settle_q <= settle_q + 4'd1;
          end
        end
        S_SAMPLE: begin
          if (bus.abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            if (diff_d && !fail_seen_q) begin
              first_fail_q <= index_q[N_IN-1:0];
              fail_seen_q  <= 1'b1;
            end
            if (last_d) begin
              state_q    <= S_FINISH;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              // last mask bit is still clear here, so fold in this sample's diff
              mismatch_q <= (|mask_w) | diff_d;
            end else begin
              state_q <= S_APPLY;
              index_q <= index_d;
              x_vec_q <= index_d[N_IN-1:0];
            end
          end
        end
        S_FINISH: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  tt_capture #(
    .IDX_W (N_IN),
    .DEPTH (DEPTH)
  ) u_capture (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (cap_clr_d),
    .we_i      (cap_we_d),
    .idx_i     (index_q[N_IN-1:0]),
    .a_i       (bus.a_in),
    .b_i       (bus.b_in),
    .table_a_o (table_a_w),
    .table_b_o (table_b_w),
    .mask_o    (mask_w)
  );

  assign bus.x_vec         = x_vec_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.table_a       = table_a_w;
  assign bus.table_b       = table_b_w;
  assign bus.mismatch_mask = mask_w;
  assign bus.mismatch      = mismatch_q;
  assign bus.first_fail    = first_fail_q;

endmodule
